// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : ctrl_pkg                                                        |
// | Brief    : Shared control encodings for the 17-bit-instruction processor.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

    localparam int c_INSTR_W = 6;
    localparam int c_FLAGS_W = 4;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_ALU_WB  = 4'd4,
        S_MEM_ADR = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WB  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_BRANCH  = 4'd9
    } state_t;

    localparam logic [1:0] c_TIPO_DATA    = 2'b00;
    localparam logic [1:0] c_TIPO_MEM     = 2'b01;
    localparam logic [1:0] c_TIPO_BRANCH  = 2'b10;
    localparam logic [1:0] c_TIPO_ILLEGAL = 2'b11;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_ORR = 2'b11;

    localparam logic [2:0] c_COND_EQ = 3'b000;
    localparam logic [2:0] c_COND_NE = 3'b001;
    localparam logic [2:0] c_COND_GE = 3'b010;
    localparam logic [2:0] c_COND_LT = 3'b011;
    localparam logic [2:0] c_COND_GT = 3'b100;
    localparam logic [2:0] c_COND_LE = 3'b101;
    localparam logic [2:0] c_COND_AL = 3'b110;
    localparam logic [2:0] c_COND_NV = 3'b111;

    localparam logic [1:0] c_IMM_DATA   = 2'b00;
    localparam logic [1:0] c_IMM_MEM    = 2'b01;
    localparam logic [1:0] c_IMM_BRANCH = 2'b10;

    localparam logic [1:0] c_RES_ALUREG  = 2'b00;
    localparam logic [1:0] c_RES_MEMDATA = 2'b01;
    localparam logic [1:0] c_RES_ALUOUT  = 2'b10;

    localparam logic [1:0] c_ALUB_REG = 2'b00;
    localparam logic [1:0] c_ALUB_IMM = 2'b01;
    localparam logic [1:0] c_ALUB_INC = 2'b10;

    typedef struct packed {
        logic [1:0] tipo;
        logic       imm;
        logic [1:0] op;
        logic       store;
        logic [2:0] cond;
    } instr_t;

    // Fields overlap: op, L/S and cond are views of the same low bits.
    function automatic instr_t decode_instr(input logic [c_INSTR_W-1:0] bits);
        instr_t d;
        d.tipo  = bits[5:4];
        d.imm   = bits[3];
        d.op    = bits[2:1];
        d.store = bits[1];
        d.cond  = bits[2:0];
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mc_sequencer_if                                                |
// | Brief     : Sequencer <-> datapath/memory control and handshake bundle.    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface mc_sequencer_if;
    import ctrl_pkg::*;

    logic [c_INSTR_W-1:0] currentInstr;
    logic [c_FLAGS_W-1:0] ALUFlags;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 MemWrite;
    logic                 AdrSrc;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 RegWrite;
    logic [1:0]           RegSrc;
    logic [1:0]           ImmSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ALUControl;
    logic [1:0]           ResultSrc;
    logic                 illegal;

    modport master (
        input  currentInstr, ALUFlags, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, illegal
    );

    modport slave (
        output currentInstr, ALUFlags, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, illegal
    );
endinterface
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cond_eval                                                       |
// | Brief    : Branch condition check of a 3-bit code against NZCV.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cond_eval
    import ctrl_pkg::*;
(
    input  wire logic [2:0] i_cond,
    input  wire logic [3:0] i_nzcv,
    output logic            o_pass
);
    logic w_n;
    logic w_z;
    logic w_v;
    logic w_unused_c;

    assign w_n        = i_nzcv[3];
    assign w_z        = i_nzcv[2];
    assign w_unused_c = i_nzcv[1];
    assign w_v        = i_nzcv[0];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            c_COND_EQ: o_pass = w_z;
            c_COND_NE: o_pass = ~w_z;
            c_COND_GE: o_pass = (w_n == w_v);
            c_COND_LT: o_pass = (w_n != w_v);
            c_COND_GT: o_pass = ~w_z & (w_n == w_v);
            c_COND_LE: o_pass = w_z | (w_n != w_v);
            c_COND_AL: o_pass = 1'b1;
            c_COND_NV: o_pass = 1'b0;
            default:   o_pass = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_sequencer                                                    |
// | Brief    : Multicycle control FSM with NZCV register and memory handshake. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mc_sequencer
    import ctrl_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    mc_sequencer_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_nzcv;
    instr_t     w_ins;
    logic       w_pass;
    logic       w_exec;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic [1:0] w_reg_src;
    logic [1:0] w_imm_src;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_ctrl;
    logic [1:0] w_result_src;
    logic       w_illegal;

    assign w_ins  = decode_instr(bus.currentInstr);
    assign w_exec = (r_state == S_EXEC_R) || (r_state == S_EXEC_I);

    cond_eval u_cond_eval (
        .i_cond (w_ins.cond),
        .i_nzcv (r_nzcv),
        .o_pass (w_pass)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Logic ops leave carry and overflow untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_nzcv <= 4'b0000;
        end else if (w_exec) begin
            r_nzcv[3:2] <= bus.ALUFlags[3:2];
            if ((w_ins.op == c_ALU_ADD) || (w_ins.op == c_ALU_SUB)) begin
                r_nzcv[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_ins.tipo)
                    c_TIPO_DATA:   w_next = w_ins.imm ? S_EXEC_I : S_EXEC_R;
                    c_TIPO_MEM:    w_next = S_MEM_ADR;
                    c_TIPO_BRANCH: w_next = w_pass ? S_BRANCH : S_FETCH;
                    default:       w_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_ALU_WB:           w_next = S_FETCH;
            S_MEM_ADR:          w_next = w_ins.store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB:           w_next = S_FETCH;
            S_MEM_WR: begin
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_BRANCH:           w_next = S_FETCH;
            default:            w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_src    = 2'b00;
        w_imm_src    = 2'b00;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = c_ALUB_REG;
        w_alu_ctrl   = c_ALU_ADD;
        w_result_src = c_RES_ALUREG;
        w_illegal    = 1'b0;

        if (r_state != S_FETCH) w_imm_src = w_ins.tipo;

        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = c_ALUB_INC;
                w_result_src = c_RES_ALUOUT;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = c_ALUB_INC;
                w_illegal   = (w_ins.tipo == c_TIPO_ILLEGAL);
            end
            S_EXEC_R: begin
                w_alu_src_b = c_ALUB_REG;
                w_alu_ctrl  = w_ins.op;
            end
            S_EXEC_I: begin
                w_alu_src_b = c_ALUB_IMM;
                w_alu_ctrl  = w_ins.op;
            end
            S_ALU_WB: begin
                w_reg_write  = 1'b1;
                w_result_src = c_RES_ALUREG;
            end
            S_MEM_ADR: begin
                w_alu_src_b = c_ALUB_IMM;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_result_src = c_RES_MEMDATA;
            end
            S_MEM_WR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                w_reg_src   = 2'b10;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = c_ALUB_IMM;
                w_result_src = c_RES_ALUOUT;
                w_pc_write   = 1'b1;
                w_reg_src    = 2'b01;
            end
            default: ;
        endcase
    end

    // Held reset silences every control line, independent of the state value.
    assign bus.mem_req    = w_mem_req    & reset;
    assign bus.MemWrite   = w_mem_write  & reset;
    assign bus.AdrSrc     = w_adr_src    & reset;
    assign bus.IRWrite    = w_ir_write   & reset;
    assign bus.PCWrite    = w_pc_write   & reset;
    assign bus.RegWrite   = w_reg_write  & reset;
    assign bus.RegSrc     = w_reg_src    & {2{reset}};
    assign bus.ImmSrc     = w_imm_src    & {2{reset}};
    assign bus.ALUSrcA    = w_alu_src_a  & reset;
    assign bus.ALUSrcB    = w_alu_src_b  & {2{reset}};
    assign bus.ALUControl = w_alu_ctrl   & {2{reset}};
    assign bus.ResultSrc  = w_result_src & {2{reset}};
    assign bus.illegal    = w_illegal    & reset;
endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mc_sequencer                                                 |
// | Brief    : Randomized self-checking bench with a phase-level control model.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mc_sequencer;
    logic clk = 1'b0;
    logic reset;

    mc_sequencer_if bus();

    mc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {P_F, P_D, P_ER, P_EI, P_WB, P_MA, P_MR, P_MWB, P_MW, P_BR} ph_t;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  m_nzcv   = 4'b0000;
    ph_t         ph_q[$];
    bit          rdy_q[$];
    logic [17:0] obs_q[$];
    logic [17:0] exp_q[$];

    function automatic bit cond_pass(input logic [2:0] c, input logic [3:0] f);
        bit n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return n == v;
            3'd3: return n != v;
            3'd4: return !z && (n == v);
            3'd5: return z || (n != v);
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Packed as {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,RegSrc,ImmSrc,ALUSrcA,ALUSrcB,ALUControl,ResultSrc,illegal}
    function automatic logic [17:0] exp_out(input ph_t p, input logic [5:0] ins, input bit rdy);
        bit f, d, ex, br, mw, mr, mwb, wb;
        logic [1:0] asb, res;
        f = (p == P_F); d = (p == P_D); br = (p == P_BR); mw = (p == P_MW);
        mr = (p == P_MR); mwb = (p == P_MWB); wb = (p == P_WB);
        ex = (p == P_ER) || (p == P_EI);
        asb = (f || d) ? 2'b10 : ((p == P_EI) || (p == P_MA) || br) ? 2'b01 : 2'b00;
        res = (f || br) ? 2'b10 : mwb ? 2'b01 : 2'b00;
        return {f | mr | mw, mw, mr | mw, f & rdy, (f & rdy) | br, wb | mwb,
                mw, br, f ? 2'b00 : ins[5:4], f | d | br, asb,
                ex ? ins[2:1] : 2'b00, res, d && (ins[5:4] == 2'b11)};
    endfunction

    task automatic add(input ph_t p, input bit r);
        ph_q.push_back(p);
        rdy_q.push_back(r);
    endtask

    task automatic plan(input logic [5:0] ins, input int fw, input int mw);
        ph_q.delete();
        rdy_q.delete();
        for (int i = 0; i <= fw; i++) add(P_F, i == fw);
        add(P_D, 1'b0);
        case (ins[5:4])
            2'b00: begin
                add(ins[3] ? P_EI : P_ER, 1'b0);
                add(P_WB, 1'b0);
            end
            2'b01: begin
                add(P_MA, 1'b0);
                for (int i = 0; i <= mw; i++) add(ins[1] ? P_MW : P_MR, i == mw);
                if (!ins[1]) add(P_MWB, 1'b0);
            end
            2'b10: if (cond_pass(ins[2:0], m_nzcv)) add(P_BR, 1'b0);
            default: ;
        endcase
    endtask

    // Drives planned cycles and records observed vs modelled outputs.
    task automatic run_instr(input logic [5:0] ins, input int xflags, input int lim);
        int n;
        bit did_exec;
        logic [3:0] fl;
        ph_t p;
        n = (lim < 0) ? ph_q.size() : lim;
        did_exec = 1'b0;
        fl = 4'b0000;
        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            p = ph_q[k];
            bus.currentInstr = (p == P_F) ? 6'($urandom) : ins;
            bus.ALUFlags = ((p == P_ER || p == P_EI) && xflags >= 0) ? 4'(xflags) : 4'($urandom);
            if (p == P_F || p == P_MR || p == P_MW) bus.mem_ready = rdy_q[k];
            else bus.mem_ready = 1'($urandom);
            if (p == P_ER || p == P_EI) begin
                did_exec = 1'b1;
                fl = bus.ALUFlags;
            end
            @(negedge clk);
            obs_q.push_back({bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
                             bus.RegWrite, bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB,
                             bus.ALUControl, bus.ResultSrc, bus.illegal});
            exp_q.push_back(exp_out(p, ins, rdy_q[k]));
            @(posedge clk);
            #1;
        end
        if (did_exec) begin
            m_nzcv[3:2] = fl[3:2];
            if (ins[2:1] == 2'b00 || ins[2:1] == 2'b01) m_nzcv[1:0] = fl[1:0];
        end
    endtask

    task automatic test_reset();
        logic [17:0] v;
        reset = 1'b0;
        bus.currentInstr = 6'b010010;
        bus.ALUFlags = 4'hF;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            v = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                 bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ResultSrc,
                 bus.illegal};
            checks++;
            if (v !== 18'd0) begin
                failures++;
                $display("FAIL reset_low cyc=%0d got=%05h exp=00000", c, v);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        m_nzcv = 4'b0000;
        checks++;
        if (dut.r_nzcv !== 4'b0000) begin
            failures++;
            $display("FAIL reset_nzcv got=%b exp=0000", dut.r_nzcv);
        end
        plan(6'b100111, 1, 0);
        run_instr(6'b100111, -1, -1);
        foreach (obs_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL reset_first_fetch cyc=%0d got=%05h exp=%05h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_data_sub();
        plan(6'b000010, 0, 0);
        run_instr(6'b000010, 4'b0110, -1);
        foreach (obs_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL data_sub cyc=%0d got=%05h exp=%05h", k, obs_q[k], exp_q[k]);
            end
        end
        checks++;
        if (dut.r_nzcv !== 4'b0110) begin
            failures++;
            $display("FAIL data_sub_nzcv got=%b exp=0110", dut.r_nzcv);
        end
    endtask

    task automatic test_load_wait();
        plan(6'b010000, 0, 3);
        run_instr(6'b010000, -1, -1);
        foreach (obs_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL load_wait cyc=%0d got=%05h exp=%05h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] seq_ins[6];
        int         seq_fl[6];
        seq_ins = '{6'b000010, 6'b100000, 6'b000010, 6'b100000, 6'b100111, 6'b100110};
        seq_fl  = '{4'b0100, -1, 4'b0000, -1, -1, -1};
        for (int i = 0; i < 6; i++) begin
            plan(seq_ins[i], i % 2, 0);
            run_instr(seq_ins[i], seq_fl[i], -1);
            foreach (obs_q[k]) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    failures++;
                    $display("FAIL branch step=%0d cyc=%0d got=%05h exp=%05h", i, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_store_orr();
        logic [5:0] seq_ins[4];
        int         seq_fl[4];
        seq_ins = '{6'b000000, 6'b010010, 6'b000110, 6'b001110};
        seq_fl  = '{4'b0011, -1, 4'b1100, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            plan(seq_ins[i], 0, 2);
            run_instr(seq_ins[i], seq_fl[i], -1);
            foreach (obs_q[k]) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    failures++;
                    $display("FAIL store_orr step=%0d cyc=%0d got=%05h exp=%05h", i, k, obs_q[k], exp_q[k]);
                end
            end
            checks++;
            if (dut.r_nzcv !== m_nzcv) begin
                failures++;
                $display("FAIL store_orr_nzcv step=%0d got=%b exp=%b", i, dut.r_nzcv, m_nzcv);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] v;
        plan(6'b000000, 0, 0);
        run_instr(6'b000000, 4'b1011, -1);
        plan(6'b010010, 0, 5);
        run_instr(6'b010010, -1, 5);
        foreach (obs_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL reset_mid_pre cyc=%0d got=%05h exp=%05h", k, obs_q[k], exp_q[k]);
            end
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        v = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
             bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ResultSrc,
             bus.illegal};
        checks++;
        if (v !== 18'd0) begin
            failures++;
            $display("FAIL reset_mid_drop got=%05h exp=00000", v);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_nzcv = 4'b0000;
        checks++;
        if (dut.r_nzcv !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_nzcv got=%b exp=0000", dut.r_nzcv);
        end
        plan(6'b001011, 0, 0);
        run_instr(6'b001011, -1, -1);
        foreach (obs_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL reset_mid_restart cyc=%0d got=%05h exp=%05h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ins;
        for (int i = 0; i < 40; i++) begin
            ins = 6'($urandom);
            plan(ins, $urandom_range(0, 2), $urandom_range(0, 2));
            run_instr(ins, -1, -1);
            foreach (obs_q[k]) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    failures++;
                    $display("FAIL random i=%0d ins=%b cyc=%0d got=%05h exp=%05h", i, ins, k, obs_q[k], exp_q[k]);
                end
            end
            checks++;
            if (dut.r_nzcv !== m_nzcv) begin
                failures++;
                $display("FAIL random_nzcv i=%0d got=%b exp=%b", i, dut.r_nzcv, m_nzcv);
            end
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.AdrSrc, bus.IRWrite} !== 3'b100) begin
            failures++;
            $display("FAIL random_final_fetch got=%b exp=100", {bus.mem_req, bus.AdrSrc, bus.IRWrite});
        end
    endtask

    initial begin
        test_reset();
        test_data_sub();
        test_load_wait();
        test_branch();
        test_store_orr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
